// File: rtl/bitonic_merge_stream_ctrl.sv
// bitonic_merge_stream_ctrl: loads two sorted runs as a bitonic vector, captures the merge result, streams it out
module bitonic_merge_stream_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH-1:0]      s_data,
  output logic [32*WIDTH-1:0]   merge_in_bus,
  input  logic [32*WIDTH-1:0]   merge_out_bus,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  sort_err
);
  typedef enum logic [1:0] {LOAD_A, LOAD_B, MERGE, DRAIN} state_t;
  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [4:0]              idx_q, idx_d;
  logic [31:0][WIDTH-1:0]  slot_q, slot_d, res_q, res_d;
  logic [WIDTH-1:0]        prev_q, prev_d;
  logic                    err_q, err_d, rdy_q, rdy_d;
  logic                    s_fire, m_fire;
  assign s_fire       = s_valid & rdy_q;
  assign m_fire       = m_ready & (state_q == DRAIN);
  assign s_ready      = rdy_q;
  assign merge_in_bus = slot_q;
  assign m_valid      = state_q == DRAIN;
  assign m_data       = res_q[idx_q];
  assign m_last       = (state_q == DRAIN) && (idx_q == 5'd31);
  assign busy         = !((state_q == LOAD_A) && (cnt_q == 4'd0));
  assign sort_err     = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    slot_d  = slot_q;
    res_d   = res_q;
    prev_d  = prev_q;
    err_d   = err_q;
    if (s_fire) begin
      // run B lands reversed in slots 31..16 so the vector is bitonic
      slot_d[(state_q == LOAD_B) ? {1'b1, ~cnt_q} : {1'b0, cnt_q}] = s_data;
      prev_d = s_data;
      cnt_d  = cnt_q + 4'd1;
      err_d  = ((state_q == LOAD_A) && (cnt_q == 4'd0)) ? 1'b0 :
               ((cnt_q != 4'd0) && (s_data < prev_q)) ? 1'b1 : err_q;
      if (cnt_q == 4'd15) state_d = (state_q == LOAD_A) ? LOAD_B : MERGE;
    end
    if (state_q == MERGE) begin
      res_d   = merge_out_bus;
      state_d = DRAIN;
    end
    if (m_fire) begin
      idx_d = idx_q + 5'd1;
      if (idx_q == 5'd31) state_d = LOAD_A;
    end
    rdy_d = (state_d == LOAD_A) || (state_d == LOAD_B);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
      idx_q   <= '0;
      slot_q  <= '0;
      res_q   <= '0;
      prev_q  <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      slot_q  <= slot_d;
      res_q   <= res_d;
      prev_q  <= prev_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end
endmodule
